drive_selector: RTL

Multi-channel successor to the single-feedback gate-drive source selector in the DRSSTC controller. Starts the bridge from the free-running generator `gen`, then hands drive over to one of `FB_CH` current-feedback channels once the resonant tank is ringing. It fails over between feedback channels, falls back to `gen` on total feedback loss, and reports the active source and a fallback count. It sits between the startup oscillator / feedback comparators and the dead-time / gate-driver stage.

---
 rtl/drive_pkg.sv | 19 +
 rtl/fb_watchdog.sv | 41 ++++
 rtl/drive_selector.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - shared types and derived constants for the gate-drive source selector
package drive_pkg;

    typedef enum logic {
        S_GEN = 1'b0,
        S_FB  = 1'b1
    } sel_state_t;

    localparam int SRC_GEN = 0;

    function automatic int timeout_cnt_max(input int clk_mhz, input int reset_timeout_us);
        return clk_mhz * reset_timeout_us;
    endfunction

    function automatic int src_w(input int fb_ch);
        return $clog2(fb_ch + 1);
    endfunction

endpackage

// File: rtl/fb_watchdog.sv
// rtl/fb_watchdog.sv - falling-edge detector plus silence watchdog for one drive input
module fb_watchdog #(
    parameter int TIMEOUT_CNT_MAX = 400
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic edge_n,
    output logic alive
);

    localparam int WD_W = $clog2(TIMEOUT_CNT_MAX + 1);
    localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CNT_MAX - 1);

    logic            pre_q, pre_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        pre_d    = x;
        wd_cnt_d = wd_cnt_q;
        if (x) begin
            wd_cnt_d = WD_RELOAD;
        end else if (wd_cnt_q != '0) begin
            wd_cnt_d = wd_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= 1'b0;
            wd_cnt_q <= '0;
        end else begin
            pre_q    <= pre_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign edge_n = ~x & pre_q;
    assign alive  = (wd_cnt_q != '0);

endmodule

// File: rtl/drive_selector.sv
// rtl/drive_selector.sv - gen/feedback drive source selector; DRIVE_SEL_FAILOVER_EN enables channel failover
module drive_selector
    import drive_pkg::*;
#(
    parameter int  CLK_MHZ           = 100,
    parameter int  FB_CH             = 2,
    parameter int  PERIODS_TO_SWITCH = 4,
    parameter int  RESET_TIMEOUT_US  = 4,
    parameter int  CNT_W             = 8,
    localparam int SRC_W             = src_w(FB_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gen,
    input  logic [FB_CH-1:0] fb,
    output logic             out,
    output logic [SRC_W-1:0] out_src,
    output logic             locked,
    output logic [CNT_W-1:0] fault_cnt
);

    localparam int TIMEOUT_CNT_MAX = timeout_cnt_max(CLK_MHZ, RESET_TIMEOUT_US);
    localparam int PER_W           = $clog2(PERIODS_TO_SWITCH + 1);
    localparam int ACT_W           = (FB_CH > 1) ? $clog2(FB_CH) : 1;

    sel_state_t       state_q, state_d;
    logic [ACT_W-1:0] active_q, active_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;

    logic             gen_n;
    logic             gen_alive_unused;
    logic [FB_CH-1:0] fb_n;
    logic [FB_CH-1:0] alive;
    logic             hand_hit;
    logic [ACT_W-1:0] hand_idx;
    logic             fall_back;

    fb_watchdog #(.TIMEOUT_CNT_MAX(TIMEOUT_CNT_MAX)) u_gen_det (
        .clk    (clk),
        .rst    (rst),
        .x      (gen),
        .edge_n (gen_n),
        .alive  (gen_alive_unused)
    );

    for (genvar g = 0; g < FB_CH; g++) begin : g_fb
        fb_watchdog #(.TIMEOUT_CNT_MAX(TIMEOUT_CNT_MAX)) u_wd (
            .clk    (clk),
            .rst    (rst),
            .x      (fb[g]),
            .edge_n (fb_n[g]),
            .alive  (alive[g])
        );
    end

`ifdef DRIVE_SEL_FAILOVER_EN
    logic             fail_hit;
    logic [ACT_W-1:0] fail_idx;
`endif

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        per_cnt_d   = per_cnt_q;
        fault_cnt_d = fault_cnt_q;
        fall_back   = 1'b0;
        hand_hit    = 1'b0;
        hand_idx    = '0;
        // descending scan so the lowest live index is the one left standing
        for (int i = FB_CH - 1; i >= 0; i--) begin
            if (fb_n[i] && alive[i]) begin
                hand_hit = 1'b1;
                hand_idx = ACT_W'(i);
            end
        end
`ifdef DRIVE_SEL_FAILOVER_EN
        fail_hit = 1'b0;
        fail_idx = '0;
        for (int i = FB_CH - 1; i >= 0; i--) begin
            if (fb_n[i] && alive[i] && (ACT_W'(i) != active_q)) begin
                fail_hit = 1'b1;
                fail_idx = ACT_W'(i);
            end
        end
`endif

        case (state_q)
            S_GEN: begin
                if (gen_n && (per_cnt_q != '0)) begin
                    per_cnt_d = per_cnt_q - 1'b1;
                end
                // gen must be low too, so the handover never clips a gen pulse
                if ((per_cnt_q == '0) && !gen && hand_hit) begin
                    state_d  = S_FB;
                    active_d = hand_idx;
                end
            end
            S_FB: begin
                if (!alive[active_q]) begin
`ifdef DRIVE_SEL_FAILOVER_EN
                    if (fail_hit) begin
                        active_d = fail_idx;
                    end else if (!(|alive) && !gen) begin
                        fall_back = 1'b1;
                    end
`else
                    if (!gen) begin
                        fall_back = 1'b1;
                    end
`endif
                end
            end
            default: state_d = S_GEN;
        endcase

        if (fall_back) begin
            state_d   = S_GEN;
            per_cnt_d = PER_W'(PERIODS_TO_SWITCH);
            if (fault_cnt_q != {CNT_W{1'b1}}) begin
                fault_cnt_d = fault_cnt_q + 1'b1;
            end
        end

        out_src_d = (state_d == S_FB) ? (SRC_W'(active_d) + SRC_W'(1)) : SRC_W'(SRC_GEN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_GEN;
            active_q    <= '0;
            per_cnt_q   <= PER_W'(PERIODS_TO_SWITCH);
            fault_cnt_q <= '0;
            out_src_q   <= SRC_W'(SRC_GEN);
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            per_cnt_q   <= per_cnt_d;
            fault_cnt_q <= fault_cnt_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out       = (state_q == S_FB) ? fb[active_q] : gen;
    assign out_src   = out_src_q;
    assign locked    = (state_q == S_FB);
    assign fault_cnt = fault_cnt_q;

endmodule
